// File: rtl/serial_tx_if.sv
// serial_tx_if: SFR-bus and pad signals of the EMC08 UART transmit controller.
// The master side is the SFR/baud-rate/pad environment; the slave side is serial_tx.
interface serial_tx_if;
    logic       serial_tx_sbuf_wr_i;
    logic [7:0] serial_tx_sbuf_data_i;
    logic       serial_tx_scon_sm0_i;
    logic       serial_tx_scon_sm1_i;
    logic       serial_tx_scon_tb8_i;
    logic       serial_tx_ti_clr_i;
    logic       serial_tx_br_trans_i;
    logic       serial_tx_start_cm_o;
    logic       serial_tx_txd_o;
    logic       serial_tx_rxd_o;
    logic       serial_tx_ti_o;
    logic       serial_tx_busy_o;

    modport master (
        output serial_tx_sbuf_wr_i, serial_tx_sbuf_data_i,
               serial_tx_scon_sm0_i, serial_tx_scon_sm1_i, serial_tx_scon_tb8_i,
               serial_tx_ti_clr_i, serial_tx_br_trans_i,
        input  serial_tx_start_cm_o, serial_tx_txd_o, serial_tx_rxd_o,
               serial_tx_ti_o, serial_tx_busy_o
    );

    modport slave (
        input  serial_tx_sbuf_wr_i, serial_tx_sbuf_data_i,
               serial_tx_scon_sm0_i, serial_tx_scon_sm1_i, serial_tx_scon_tb8_i,
               serial_tx_ti_clr_i, serial_tx_br_trans_i,
        output serial_tx_start_cm_o, serial_tx_txd_o, serial_tx_rxd_o,
               serial_tx_ti_o, serial_tx_busy_o
    );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: UART transmit sequencer for SCON modes 0-3. A frame is loaded by an
// SBUF write in IDLE and advanced by baud-rate ticks; every output is registered.
module serial_tx (
    input  logic       system_clk_i,
    input  logic       system_rst_i_b,
    serial_tx_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } mode_t;

    state_t     state_q, state_d;
    mode_t      mode_q, mode_d;
    logic [7:0] data_q, data_d;
    logic       tb8_q, tb8_d;
    logic [4:0] cnt_q, cnt_d;
    logic       txd_q, txd_d;
    logic       rxd_q, rxd_d;
    logic       ti_q, ti_d;
    logic       busy_q, busy_d;
    logic       start_q, start_d;

    logic       load;
    logic       tick;
    logic       frame_end;
    logic [4:0] end_cnt;
    logic [2:0] async_idx;

    // A write is only honoured in IDLE; a tick only counts while a frame is in flight.
    assign load      = (state_q == IDLE) && bus.serial_tx_sbuf_wr_i;
    assign tick      = (state_q == SHIFT) && bus.serial_tx_br_trans_i;
    assign frame_end = tick && (cnt_q + 5'd1 == end_cnt);
    // Tick k (1..8) of an asynchronous frame carries data bit k-1.
    assign async_idx = cnt_d[2:0] - 3'd1;

    // Frame length in ticks for the mode latched at load.
    always_comb begin
        unique case (mode_q)
            MODE0:   end_cnt = 5'd16;
            MODE1:   end_cnt = 5'd10;
            default: end_cnt = 5'd11;
        endcase
    end

    // State register plus registered outputs.
    always_ff @(posedge system_clk_i or negedge system_rst_i_b) begin
        if (!system_rst_i_b) begin
            state_q <= IDLE;
            mode_q  <= MODE0;
            data_q  <= '0;
            tb8_q   <= 1'b0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            rxd_q   <= 1'b1;
            ti_q    <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            tb8_q   <= tb8_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            rxd_q   <= rxd_d;
            ti_q    <= ti_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    // Next-state: load latches the frame parameters, ticks advance a saturating counter.
    always_comb begin
        // NOTE: hold-value defaults first so no path through this block infers a latch.
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        tb8_d   = tb8_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = SHIFT;
            mode_d  = mode_t'({bus.serial_tx_scon_sm0_i, bus.serial_tx_scon_sm1_i});
            data_d  = bus.serial_tx_sbuf_data_i;
            tb8_d   = bus.serial_tx_scon_tb8_i;
            cnt_d   = '0;
        end else if (tick) begin
            cnt_d = (cnt_q == end_cnt) ? cnt_q : cnt_q + 5'd1;
            if (frame_end) begin
                state_d = IDLE;
            end
        end
    end

    // Output decode: next pad/flag values derived from the upcoming counter value.
    always_comb begin
        txd_d   = txd_q;
        rxd_d   = rxd_q;
        ti_d    = ti_q;
        busy_d  = (state_d == SHIFT);
        start_d = load;

        // Frame-end set has priority over a software clear in the same cycle.
        if (bus.serial_tx_ti_clr_i) begin
            ti_d = 1'b0;
        end
        if (frame_end) begin
            ti_d = 1'b1;
        end

        if (load) begin
            // Start bit in async modes; shift clock low with D0 on RXD in mode 0.
            txd_d = 1'b0;
            rxd_d = (mode_d == MODE0) ? data_d[0] : 1'b1;
        end else if (frame_end) begin
            txd_d = 1'b1;
            rxd_d = 1'b1;
        end else if (tick) begin
            if (mode_q == MODE0) begin
                if (cnt_d[0]) begin
                    txd_d = 1'b1;
                end else begin
                    txd_d = 1'b0;
                    rxd_d = data_q[cnt_d[3:1]];
                end
            end else if (cnt_d <= 5'd8) begin
                txd_d = data_q[async_idx];
            end else if (cnt_d == 5'd9 && mode_q != MODE1) begin
                txd_d = tb8_q;
            end else begin
                txd_d = 1'b1;
            end
        end
    end

    assign bus.serial_tx_txd_o      = txd_q;
    assign bus.serial_tx_rxd_o      = rxd_q;
    assign bus.serial_tx_ti_o       = ti_q;
    assign bus.serial_tx_busy_o     = busy_q;
    assign bus.serial_tx_start_cm_o = start_q;
endmodule

// File: doc/serial_tx.md
# serial_tx

Serial-port transmit controller for the EMC08 UART. It sequences a frame out of the transmit buffer, consumes the per-bit transmit tick from `baud_rate` (`baud_rate_br_trans_o`), and restarts the baud counter at frame start. It supports all four SCON modes: mode 0 is the shift register; modes 1, 2 and 3 are asynchronous with 8 or 9 data bits. It sits between the SFR bus (SBUF/SCON writes) and the TXD/RXD pads, and raises TI for the interrupt controller.

## Interface
- No parameters. Data width is fixed at 8 bits; the ninth bit is TB8.
- `system_clk_i`  in  1  system clock; all logic on rising edge
- `system_rst_i_b`  in  1  reset, asynchronous, active-low
- `serial_tx_sbuf_wr_i`  in  1  one-cycle SBUF write strobe
- `serial_tx_sbuf_data_i`  in  8  SBUF write data
- `serial_tx_scon_sm0_i`, `serial_tx_scon_sm1_i`  in  1 each  SCON mode bits
- `serial_tx_scon_tb8_i`  in  1  ninth bit, used in modes 2 and 3
- `serial_tx_ti_clr_i`  in  1  software clear of TI
- `serial_tx_br_trans_i`  in  1  one-cycle bit tick from `baud_rate`
- `serial_tx_start_cm_o`  out  1  one-cycle pulse that restarts the `baud_rate` counter
- `serial_tx_txd_o`  out  1  TXD pad: serial data in modes 1-3, shift clock in mode 0
- `serial_tx_rxd_o`  out  1  RXD pad data in mode 0; 1 otherwise
- `serial_tx_ti_o`  out  1  transmit-complete flag (SCON.TI)
- `serial_tx_busy_o`  out  1  frame in progress

## Operation
- Mode encoding: {sm0, sm1}. 00 = mode 0, 01 = mode 1, 10 = mode 2, 11 = mode 3.
- States:
  - IDLE: `txd_o` = 1, `rxd_o` = 1, `busy_o` = 0.
  - On write: go to SHIFT. Latch the data byte, TB8 and the mode. Clear the tick counter.
  - In SHIFT, each tick increments the counter. Ticks with `busy_o` = 0 are ignored.
- Mode 1 (10-bit frame):
  - On load, `txd_o` drives the start bit (0).
  - Tick k, for k = 1..8, drives D(k-1), LSB first.
  - Tick 9 drives the stop bit (1).
  - Tick 10 ends the frame.
- Modes 2 and 3 (11-bit frame): same as mode 1, except tick 9 drives TB8, tick 10 drives the stop bit, and tick 11 ends the frame.
- Mode 0 (16 ticks, two ticks per bit):
  - On load, `rxd_o` = D0 and `txd_o` = 0.
  - Odd tick: `txd_o` = 1; the receiver samples on this rising edge.
  - Even tick 2j, for j < 8: `rxd_o` = Dj and `txd_o` = 0.
  - Tick 16 ends the frame.
- Frame end: return to IDLE and set `ti_o` = 1. `txd_o` and `rxd_o` go to 1.
- TI clear:
  - `ti_clr_i` clears TI.
  - If the clear and frame end occur in the same cycle, set wins (TI = 1).
- SBUF write while busy is ignored. The frame continues unchanged and `start_cm_o` does not pulse.
- A mode or TB8 change mid-frame has no effect; the values latched at load are used.
- A write in IDLE while `ti_o` = 1 is accepted; TI stays 1 until cleared.

## Timing
- Reset values: `txd_o` = 1, `rxd_o` = 1, `ti_o` = 0, `busy_o` = 0, `start_cm_o` = 0. The tick counter and shift register are 0.
- Write accepted at edge N. In cycle N+1:
  - `busy_o` = 1.
  - `start_cm_o` = 1 for exactly one cycle.
  - The first bit is on the pad (start bit, or D0 and shift clock low in mode 0).
- A `br_trans_i` pulse in the same cycle as the accepting write is ignored.
- Every output change from a tick is visible the cycle after the tick edge. All outputs are registered, with no combinational input-to-output path.
- `ti_o` rises in the same cycle that `busy_o` falls.
- A new write is accepted in the cycle after `busy_o` falls.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronously). It discards the frame and does not set TI.
- The tick counter is 5 bits wide and saturates at its end value; it never wraps.

## Test plan
- Mode 1, write 0xA5:
  - `start_cm_o` pulses once.
  - TXD sequence 0,1,0,1,0,0,1,0,1,1 across the ticks.
  - TI = 1 and busy = 0 after tick 10.
- Mode 3, TB8 = 1, write 0x3C: TXD is 0, 0,0,1,1,1,1,0,0, 1, 1; TI sets after tick 11.
- Mode 0, write 0x81:
  - RXD presents 1,0,0,0,0,0,0,1.
  - TXD toggles 0/1 eight times.
  - TI sets after tick 16.
  - Both pads return to 1.
- Write during a frame (0x11, then 0xFF at tick 4): the frame still sends 0x11, there is no second `start_cm_o`, and TI sets once.
- `ti_clr_i` asserted in the same cycle as the frame-end tick: TI = 1. A later clear gives TI = 0.
- Reset asserted at tick 5 of a mode-2 frame: all outputs return to reset values immediately. Ticks after release have no effect, and the next write starts a clean frame.
